// File: rtl/shoal_handler_pkg.sv
// Shared definitions for the Active Message handler dispatch path:
// header field positions and the dispatcher state encoding.
package shoal_handler_pkg;

  localparam int AM_DEST_LSB    = 24;
  localparam int AM_DEST_MSB    = 39;
  localparam int AM_HANDLER_LSB = 56;
  localparam int AM_HANDLER_MSB = 59;
  localparam int AM_HANDLER_W   = AM_HANDLER_MSB - AM_HANDLER_LSB + 1;

  typedef enum logic [1:0] {
    ST_HEADER = 2'd0,
    ST_FWD    = 2'd1,
    ST_DROP   = 2'd2
  } dispatch_state_e;

endpackage

// File: rtl/am_dispatch_out_stage.sv
// One-entry registered output stage shared by all kernel channels; valid is
// demultiplexed by the stored channel tag and ready is selected by it.
module am_dispatch_out_stage
  import shoal_handler_pkg::*;
#(
  parameter int NUM_KERNELS  = 2,
  parameter int DATA_WIDTH   = 64,
  parameter int KERNEL_WIDTH = 1
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    load,
  input  logic [DATA_WIDTH-1:0]   load_data,
  input  logic                    load_last,
  input  logic [KERNEL_WIDTH-1:0] load_sel,
  input  logic [AM_HANDLER_W-1:0] load_handler,
  output logic                    can_load,
  output logic [DATA_WIDTH-1:0]   m_axis_tdata,
  output logic                    m_axis_tlast,
  output logic [NUM_KERNELS-1:0]  m_axis_tvalid,
  input  logic [NUM_KERNELS-1:0]  m_axis_tready,
  output logic [AM_HANDLER_W-1:0] m_handler_id
);

  logic                    out_valid_reg;
  logic [DATA_WIDTH-1:0]   data_reg;
  logic                    last_reg;
  logic [KERNEL_WIDTH-1:0] out_sel_reg;
  logic [AM_HANDLER_W-1:0] handler_reg;
  logic                    unload;

  assign unload   = out_valid_reg && m_axis_tready[out_sel_reg];
  // A beat may enter while the previous one leaves, giving full-rate flow.
  assign can_load = !out_valid_reg || m_axis_tready[out_sel_reg];

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      out_valid_reg <= 1'b0;
      data_reg      <= '0;
      last_reg      <= 1'b0;
      out_sel_reg   <= '0;
      handler_reg   <= '0;
    end else if (load) begin
      out_valid_reg <= 1'b1;
      data_reg      <= load_data;
      last_reg      <= load_last;
      out_sel_reg   <= load_sel;
      handler_reg   <= load_handler;
    end else if (unload) begin
      out_valid_reg <= 1'b0;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_KERNELS; gi++) begin : g_valid_demux
      assign m_axis_tvalid[gi] = out_valid_reg && (out_sel_reg == KERNEL_WIDTH'(gi));
    end
  endgenerate

  assign m_axis_tdata = data_reg;
  assign m_axis_tlast = last_reg;
  assign m_handler_id = handler_reg;

endmodule

// File: rtl/am_handler_dispatch.sv
// Active Message handler dispatcher: routes each packet to a per-kernel stream
// by its header destination, dropping out-of-range packets.
// Define AM_HANDLER_DISPATCH_STATS_EN to build the per-channel packet counters.
module am_handler_dispatch
  import shoal_handler_pkg::*;
#(
  parameter int NUM_KERNELS = 2,
  parameter int DATA_WIDTH  = 64,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                             clock,
  input  logic                             reset_n,
  input  logic [DATA_WIDTH-1:0]            axis_handler_tdata,
  input  logic                             axis_handler_tlast,
  input  logic                             axis_handler_tvalid,
  output logic                             axis_handler_tready,
  input  logic [15:0]                      address_offset,
  output logic [DATA_WIDTH-1:0]            m_axis_tdata,
  output logic                             m_axis_tlast,
  output logic [NUM_KERNELS-1:0]           m_axis_tvalid,
  input  logic [NUM_KERNELS-1:0]           m_axis_tready,
  output logic [3:0]                       m_handler_id,
  output logic [CNT_WIDTH-1:0]             drop_count,
  output logic [NUM_KERNELS*CNT_WIDTH-1:0] pkt_count
);

  localparam int KERNEL_WIDTH = (NUM_KERNELS == 1) ? 1 : $clog2(NUM_KERNELS);

  dispatch_state_e         state_reg, state_next;
  logic [KERNEL_WIDTH-1:0] sel_reg, sel_next;
  logic [AM_HANDLER_W-1:0] handler_reg, handler_next;
  logic [CNT_WIDTH-1:0]    drop_count_reg;

  logic [15:0]             hdr_dest;
  logic [AM_HANDLER_W-1:0] hdr_handler;
  logic [KERNEL_WIDTH-1:0] hdr_sel;
  logic                    in_range;
  logic                    tready_int;
  logic                    accept;
  logic                    load;
  logic [KERNEL_WIDTH-1:0] load_sel;
  logic [AM_HANDLER_W-1:0] load_handler;
  logic                    drop_inc;
  logic                    can_load;

  // Modular subtraction: IDs below the offset wrap high and fall out of range.
  assign hdr_dest    = axis_handler_tdata[AM_DEST_MSB:AM_DEST_LSB] - address_offset;
  assign hdr_handler = axis_handler_tdata[AM_HANDLER_MSB:AM_HANDLER_LSB];
  assign hdr_sel     = hdr_dest[KERNEL_WIDTH-1:0];
  assign in_range    = hdr_dest < 16'(NUM_KERNELS);

  always_comb begin
    tready_int = 1'b0;
    case (state_reg)
      ST_HEADER: tready_int = in_range ? can_load : 1'b1;
      ST_FWD:    tready_int = can_load;
      ST_DROP:   tready_int = 1'b1;
      default:   tready_int = 1'b0;
    endcase
  end

  assign axis_handler_tready = tready_int && reset_n;
  assign accept              = axis_handler_tvalid && axis_handler_tready;

  always_comb begin
    state_next   = state_reg;
    sel_next     = sel_reg;
    handler_next = handler_reg;
    load         = 1'b0;
    load_sel     = sel_reg;
    load_handler = handler_reg;
    drop_inc     = 1'b0;
    case (state_reg)
      ST_HEADER: begin
        if (accept) begin
          if (in_range) begin
            load         = 1'b1;
            load_sel     = hdr_sel;
            load_handler = hdr_handler;
            sel_next     = hdr_sel;
            handler_next = hdr_handler;
            state_next   = axis_handler_tlast ? ST_HEADER : ST_FWD;
          end else begin
            drop_inc   = 1'b1;
            state_next = axis_handler_tlast ? ST_HEADER : ST_DROP;
          end
        end
      end
      ST_FWD: begin
        if (accept) begin
          load = 1'b1;
          if (axis_handler_tlast) state_next = ST_HEADER;
        end
      end
      ST_DROP: begin
        if (accept && axis_handler_tlast) state_next = ST_HEADER;
      end
      default: state_next = ST_HEADER;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_reg      <= ST_HEADER;
      sel_reg        <= '0;
      handler_reg    <= '0;
      drop_count_reg <= '0;
    end else begin
      state_reg   <= state_next;
      sel_reg     <= sel_next;
      handler_reg <= handler_next;
      if (drop_inc && drop_count_reg != {CNT_WIDTH{1'b1}})
        drop_count_reg <= drop_count_reg + CNT_WIDTH'(1);
    end
  end

  assign drop_count = drop_count_reg;

  am_dispatch_out_stage #(
    .NUM_KERNELS  (NUM_KERNELS),
    .DATA_WIDTH   (DATA_WIDTH),
    .KERNEL_WIDTH (KERNEL_WIDTH)
  ) u_out_stage (
    .clock         (clock),
    .reset_n       (reset_n),
    .load          (load),
    .load_data     (axis_handler_tdata),
    .load_last     (axis_handler_tlast),
    .load_sel      (load_sel),
    .load_handler  (load_handler),
    .can_load      (can_load),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_handler_id  (m_handler_id)
  );

`ifdef AM_HANDLER_DISPATCH_STATS_EN
  genvar gi;
  generate
    for (gi = 0; gi < NUM_KERNELS; gi++) begin : g_pkt_cnt
      logic [CNT_WIDTH-1:0] cnt_reg;
      always_ff @(posedge clock) begin
        if (!reset_n)
          cnt_reg <= '0;
        else if (m_axis_tvalid[gi] && m_axis_tready[gi] && m_axis_tlast &&
                 cnt_reg != {CNT_WIDTH{1'b1}})
          cnt_reg <= cnt_reg + CNT_WIDTH'(1);
      end
      assign pkt_count[gi*CNT_WIDTH +: CNT_WIDTH] = cnt_reg;
    end
  endgenerate
`else
  assign pkt_count = '0;
`endif

endmodule

// File: tb/tb_am_handler_dispatch.sv
// Directed scoreboard bench for am_handler_dispatch with NUM_KERNELS = 4.
module tb_am_handler_dispatch;
  import shoal_handler_pkg::*;

  localparam int NK = 4;
  localparam int DW = 64;
  localparam int CW = 16;
`ifdef AM_HANDLER_DISPATCH_STATS_EN
  localparam int STATS = 1;
`else
  localparam int STATS = 0;
`endif

  logic             clock = 1'b0;
  logic             reset_n = 1'b0;
  logic [DW-1:0]    axis_handler_tdata = '0;
  logic             axis_handler_tlast = 1'b0;
  logic             axis_handler_tvalid = 1'b0;
  logic             axis_handler_tready;
  logic [15:0]      address_offset = 16'h0010;
  logic [DW-1:0]    m_axis_tdata;
  logic             m_axis_tlast;
  logic [NK-1:0]    m_axis_tvalid;
  logic [NK-1:0]    m_axis_tready = '1;
  logic [3:0]       m_handler_id;
  logic [CW-1:0]    drop_count;
  logic [NK*CW-1:0] pkt_count;

  am_handler_dispatch #(.NUM_KERNELS(NK), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clock               (clock),
    .reset_n             (reset_n),
    .axis_handler_tdata  (axis_handler_tdata),
    .axis_handler_tlast  (axis_handler_tlast),
    .axis_handler_tvalid (axis_handler_tvalid),
    .axis_handler_tready (axis_handler_tready),
    .address_offset      (address_offset),
    .m_axis_tdata        (m_axis_tdata),
    .m_axis_tlast        (m_axis_tlast),
    .m_axis_tvalid       (m_axis_tvalid),
    .m_axis_tready       (m_axis_tready),
    .m_handler_id        (m_handler_id),
    .drop_count          (drop_count),
    .pkt_count           (pkt_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    int          ch;
    logic [63:0] data;
    logic        last;
    logic [3:0]  hid;
    int          cyc;
  } beat_t;

  beat_t q[$];
  int    n_cmp = 0;
  int    n_err = 0;
  int    cyc = 0;
  int    stalls = 0;
  int    valid_cycles = 0;
  int    hold_cycles = 0;
  bit    chk_lat = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Output monitor: pops one expected beat per completed output transfer.
  bit          prev_hold = 1'b0;
  logic [63:0] prev_data;
  logic        prev_last;
  logic [NK-1:0] prev_valid;
  always @(negedge clock) begin
    if (reset_n) begin
      if (m_axis_tvalid != '0) valid_cycles++;
      if (prev_hold) begin
        check("hold_valid", 64'(m_axis_tvalid), 64'(prev_valid));
        check("hold_data", m_axis_tdata, prev_data);
        check("hold_last", 64'(m_axis_tlast), 64'(prev_last));
      end
      prev_hold = 1'b0;
      if ($countones(m_axis_tvalid) > 1) check("onehot", 64'(m_axis_tvalid), 64'(0));
      for (int k = 0; k < NK; k++) begin
        if (m_axis_tvalid[k] && !m_axis_tready[k]) begin
          prev_hold  = 1'b1;
          prev_data  = m_axis_tdata;
          prev_last  = m_axis_tlast;
          prev_valid = m_axis_tvalid;
          if (k == 1) hold_cycles++;
        end
        if (m_axis_tvalid[k] && m_axis_tready[k]) begin
          if (q.size() == 0) begin
            check("unexpected_beat", 64'(k), 64'(-1));
          end else begin
            beat_t e;
            e = q.pop_front();
            check("channel", 64'(k), 64'(e.ch));
            check("data", m_axis_tdata, e.data);
            check("last", 64'(m_axis_tlast), 64'(e.last));
            check("handler", 64'(m_handler_id), 64'(e.hid));
            if (chk_lat) check("latency", 64'(cyc - e.cyc), 64'(1));
          end
        end
      end
    end
  end

  task automatic send_beat(input logic [63:0] d, input logic last, input int ch, input logic [3:0] hid);
    bit acc = 1'b0;
    int c = 0;
    axis_handler_tdata  = d;
    axis_handler_tlast  = last;
    axis_handler_tvalid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (axis_handler_tready) begin
        acc = 1'b1;
        c = cyc;
        break;
      end
      stalls++;
    end
    if (!acc) begin
      check("input_timeout", 64'(0), 64'(1));
    end else begin
      @(posedge clock);
      if (ch >= 0) q.push_back('{ch: ch, data: d, last: last, hid: hid, cyc: c});
    end
    #1 axis_handler_tvalid = 1'b0;
  endtask

  task automatic send_pkt(input logic [15:0] dest_field, input logic [3:0] hid, input int nbeats);
    logic [15:0] dest;
    logic [63:0] d;
    int ch;
    dest = dest_field - address_offset;
    ch = (dest < 16'(NK)) ? int'(dest) : -1;
    for (int i = 0; i < nbeats; i++) begin
      d = {$urandom, $urandom};
      if (i == 0) begin
        d[39:24] = dest_field;
        d[59:56] = hid;
      end
      send_beat(d, i == nbeats - 1, ch, hid);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && q.size() != 0; i++) @(posedge clock);
    check("drain_empty", 64'(q.size()), 64'(0));
    @(posedge clock);
    #1;
  endtask

  function automatic logic [CW-1:0] pc(input int k);
    return pkt_count[k*CW +: CW];
  endfunction

  initial begin
    logic [63:0] d;
    int v0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_tready", 64'(axis_handler_tready), 64'(0));
    check("rst_tvalid", 64'(m_axis_tvalid), 64'(0));
    check("rst_tdata", m_axis_tdata, 64'(0));
    check("rst_tlast", 64'(m_axis_tlast), 64'(0));
    check("rst_handler", 64'(m_handler_id), 64'(0));
    check("rst_drop", 64'(drop_count), 64'(0));
    check("rst_pkt", 64'(pkt_count), 64'(0));
    @(posedge clock);
    #1 reset_n = 1'b1;

    // 3-beat packet to channel 2, one cycle latency.
    chk_lat = 1'b1;
    stalls = 0;
    send_pkt(16'h0012, 4'hA, 3);
    drain();
    check("t1_pkt2", 64'(pc(2)), 64'(STATS));
    check("t1_stalls", 64'(stalls), 64'(0));

    // Header-only packet to channel 1.
    send_pkt(16'h0011, 4'h5, 1);
    drain();
    check("t2_pkt1", 64'(pc(1)), 64'(STATS));
    check("t2_state", 64'(dut.state_reg), 64'(ST_HEADER));

    // Wrapped destination: whole packet swallowed without back-pressure.
    stalls = 0;
    v0 = valid_cycles;
    send_pkt(16'h0005, 4'h7, 4);
    repeat (3) @(posedge clock);
    #1;
    check("t3_stalls", 64'(stalls), 64'(0));
    check("t3_no_valid", 64'(valid_cycles - v0), 64'(0));
    check("t3_drop", 64'(drop_count), 64'(1));
    check("t3_state", 64'(dut.state_reg), 64'(ST_HEADER));

    // Back-to-back packets to channels 0 and 3, full rate.
    stalls = 0;
    send_pkt(16'h0010, 4'h1, 3);
    send_pkt(16'h0013, 4'h3, 2);
    drain();
    check("t4_stalls", 64'(stalls), 64'(0));
    check("t4_pkt0", 64'(pc(0)), 64'(STATS));
    check("t4_pkt3", 64'(pc(3)), 64'(STATS));

    // Channel 1 back-pressure for 5 cycles mid-packet.
    chk_lat = 1'b0;
    stalls = 0;
    hold_cycles = 0;
    fork
      send_pkt(16'h0011, 4'hC, 6);
      begin
        repeat (3) @(posedge clock);
        #1 m_axis_tready[1] = 1'b0;
        repeat (5) @(posedge clock);
        #1 m_axis_tready[1] = 1'b1;
      end
    join
    drain();
    check("t5_hold_cycles", 64'(hold_cycles), 64'(5));
    check("t5_input_stalled", 64'(stalls > 0), 64'(1));
    check("t5_pkt1", 64'(pc(1)), 64'(2 * STATS));

    // Reset mid-packet, then a fresh header must decode normally.
    chk_lat = 1'b1;
    d = {$urandom, $urandom};
    d[39:24] = 16'h0012;
    d[59:56] = 4'h9;
    send_beat(d, 1'b0, 2, 4'h9);
    send_beat({$urandom, $urandom}, 1'b0, 2, 4'h9);
    reset_n = 1'b0;
    @(posedge clock);
    #1;
    check("mr_tready", 64'(axis_handler_tready), 64'(0));
    check("mr_tvalid", 64'(m_axis_tvalid), 64'(0));
    check("mr_tdata", m_axis_tdata, 64'(0));
    check("mr_tlast", 64'(m_axis_tlast), 64'(0));
    check("mr_handler", 64'(m_handler_id), 64'(0));
    check("mr_drop", 64'(drop_count), 64'(0));
    check("mr_pkt", 64'(pkt_count), 64'(0));
    q.delete();
    reset_n = 1'b1;
    send_pkt(16'h0010, 4'h6, 1);
    drain();
    check("mr_pkt0", 64'(pc(0)), 64'(STATS));
    check("mr_pkt2", 64'(pc(2)), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
